// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game-flow FSM for the bubble game.
// Sequences start screen, level load, play, life loss/respawn, level clear,
// win and lose. Keeps lives/level registers and its own hold timer; all
// outputs are a Moore decode of the registered state.
module game_flow_ctrl #(
    parameter int LIVES_INIT  = 3,
    parameter int MAX_LIVES   = 9,
    parameter int LIFE_W      = 4,
    parameter int NUM_LEVELS  = 4,
    parameter int LEVEL_W     = 2,
    parameter int HOLD_CYCLES = 50000000,
    parameter int BONUS_LIFE  = 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startBtn,
    input  logic               charHit,
    input  logic               levelClear,
    input  logic               timeUp,
    output logic               bubbleStart,
    output logic               charStart,
    output logic               freeze,
    output logic [LIFE_W-1:0]  lives,
    output logic [LEVEL_W-1:0] level,
    output logic               displayMessage,
    output logic [1:0]         message
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LIFE_W-1:0]  LIVES_RST  = LIFE_W'(LIVES_INIT);
    localparam logic [LIFE_W-1:0]  LIVES_CAP  = LIFE_W'(MAX_LIVES);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

    localparam logic [1:0] MSG_CLEAR = 2'b00;
    localparam logic [1:0] MSG_WIN   = 2'b01;
    localparam logic [1:0] MSG_LOSE  = 2'b10;
    localparam logic [1:0] MSG_START = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_LEVEL = 3'd1,
        ST_PLAY       = 3'd2,
        ST_LIFE_LOST  = 3'd3,
        ST_RESPAWN    = 3'd4,
        ST_LEVEL_DONE = 3'd5,
        ST_WIN        = 3'd6,
        ST_LOSE       = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [LIFE_W-1:0]    lives_q, lives_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // State, lives, level and hold-counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            lives_q <= LIVES_RST;
            level_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, register updates and Moore output decode
    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        level_d        = level_q;
        cnt_d          = cnt_q;
        bubbleStart    = 1'b0;
        charStart      = 1'b0;
        freeze         = 1'b0;
        displayMessage = 1'b0;
        message        = 2'b00;

        case (state_q)
            ST_IDLE: begin
                freeze         = 1'b1;
                displayMessage = 1'b1;
                message        = MSG_START;
                if (startBtn) state_d = ST_LOAD_LEVEL;
            end
            ST_LOAD_LEVEL: begin
                bubbleStart = 1'b1;
                charStart   = 1'b1;
                state_d     = ST_PLAY;
            end
            ST_PLAY: begin
                charStart = 1'b1;
                // A clear in the same cycle as a hit wins; no life is lost
                if (levelClear) begin
                    cnt_d   = '0;
                    state_d = ST_LEVEL_DONE;
                end else if (charHit || timeUp) begin
                    lives_d = (lives_q != '0) ? lives_q - LIFE_W'(1) : '0;
                    cnt_d   = '0;
                    state_d = ST_LIFE_LOST;
                end
            end
            ST_LIFE_LOST: begin
                freeze = 1'b1;
                // Out of lives: go straight to the lose screen, no hold
                if (lives_q == '0) begin
                    state_d = ST_LOSE;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RESPAWN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESPAWN: begin
                // Character only; bubbles keep their positions
                charStart = 1'b1;
                state_d   = ST_PLAY;
            end
            ST_LEVEL_DONE: begin
                freeze         = 1'b1;
                displayMessage = 1'b1;
                message        = MSG_CLEAR;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (level_q == LAST_LEVEL) begin
                        state_d = ST_WIN;
                    end else begin
                        level_d = level_q + LEVEL_W'(1);
                        if ((BONUS_LIFE != 0) && (lives_q < LIVES_CAP))
                            lives_d = lives_q + LIFE_W'(1);
                        state_d = ST_LOAD_LEVEL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WIN, ST_LOSE: begin
                freeze         = 1'b1;
                displayMessage = 1'b1;
                message        = (state_q == ST_WIN) ? MSG_WIN : MSG_LOSE;
                // Sticky until a restart request reloads the game
                if (startBtn) begin
                    lives_d = LIVES_RST;
                    level_d = '0;
                    cnt_d   = '0;
                    state_d = ST_LOAD_LEVEL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign lives = lives_q;
    assign level = level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed scoreboard bench for game_flow_ctrl with
// short hold time (4 cycles) and two levels.
module tb_game_flow_ctrl;

    localparam int LIFE_W  = 4;
    localparam int LEVEL_W = 2;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               startBtn = 1'b0;
    logic               charHit = 1'b0;
    logic               levelClear = 1'b0;
    logic               timeUp = 1'b0;
    logic               bubbleStart, charStart, freeze, displayMessage;
    logic [LIFE_W-1:0]  lives;
    logic [LEVEL_W-1:0] level;
    logic [1:0]         message;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    game_flow_ctrl #(
        .LIVES_INIT (3),
        .MAX_LIVES  (9),
        .LIFE_W     (LIFE_W),
        .NUM_LEVELS (2),
        .LEVEL_W    (LEVEL_W),
        .HOLD_CYCLES(4),
        .BONUS_LIFE (1)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startBtn      (startBtn),
        .charHit       (charHit),
        .levelClear    (levelClear),
        .timeUp        (timeUp),
        .bubbleStart   (bubbleStart),
        .charStart     (charStart),
        .freeze        (freeze),
        .lives         (lives),
        .level         (level),
        .displayMessage(displayMessage),
        .message       (message)
    );

    always #5 clk = ~clk;

    // Expected output vector: {bubbleStart,charStart,freeze,lives,level,displayMessage,message}
    function automatic logic [11:0] mk(input logic bs, input logic cs, input logic fr,
                                       input logic [3:0] lv, input logic [1:0] lev,
                                       input logic dm, input logic [1:0] msg);
        return {bs, cs, fr, lv, lev, dm, msg};
    endfunction

    function automatic logic [11:0] e_idle(input logic [3:0] l, input logic [1:0] v);
        return mk(0, 0, 1, l, v, 1, 2'b11);
    endfunction
    function automatic logic [11:0] e_load(input logic [3:0] l, input logic [1:0] v);
        return mk(1, 1, 0, l, v, 0, 2'b00);
    endfunction
    function automatic logic [11:0] e_play(input logic [3:0] l, input logic [1:0] v);
        return mk(0, 1, 0, l, v, 0, 2'b00);
    endfunction
    function automatic logic [11:0] e_lost(input logic [3:0] l, input logic [1:0] v);
        return mk(0, 0, 1, l, v, 0, 2'b00);
    endfunction
    function automatic logic [11:0] e_resp(input logic [3:0] l, input logic [1:0] v);
        return mk(0, 1, 0, l, v, 0, 2'b00);
    endfunction
    function automatic logic [11:0] e_done(input logic [3:0] l, input logic [1:0] v);
        return mk(0, 0, 1, l, v, 1, 2'b00);
    endfunction
    function automatic logic [11:0] e_win(input logic [3:0] l, input logic [1:0] v);
        return mk(0, 0, 1, l, v, 1, 2'b01);
    endfunction
    function automatic logic [11:0] e_lose(input logic [3:0] l, input logic [1:0] v);
        return mk(0, 0, 1, l, v, 1, 2'b10);
    endfunction

    // Drive one cycle of inputs, queue the expectation, then compare after the edge
    task automatic cyc(input logic rn, input logic sb, input logic hit, input logic tu,
                       input logic clr, input string tag, input logic [11:0] e);
        sb_item_t it;
        sb_item_t got;
        logic [11:0] obs;
        it.tag = tag;
        it.exp = e;
        sb_q.push_back(it);
        resetN     = rn;
        startBtn   = sb;
        charHit    = hit;
        timeUp     = tu;
        levelClear = clr;
        @(posedge clk);
        #1;
        obs = {bubbleStart, charStart, freeze, lives, level, displayMessage, message};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            got = sb_q.pop_front();
            assert (obs === got.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", got.tag, obs, got.exp);
            end
        end
        $display("step %-12s obs=%h", tag, obs);
    endtask

    // Idle cycle with no events
    task automatic nop(input string tag, input logic [11:0] e);
        cyc(1, 0, 0, 0, 0, tag, e);
    endtask

    // Remaining LIFE_LOST hold cycles, then RESPAWN and back to PLAY
    task automatic hold_respawn(input logic [3:0] l, input logic [1:0] v);
        for (int i = 0; i < 3; i++) nop("lost_hold", e_lost(l, v));
        nop("respawn", e_resp(l, v));
        nop("play_back", e_play(l, v));
    endtask

    initial begin
        // Reset and idle screen
        cyc(0, 0, 0, 0, 0, "reset0", e_idle(3, 0));
        cyc(0, 1, 1, 0, 0, "reset1", e_idle(3, 0));
        cyc(1, 0, 1, 1, 1, "idle_gate", e_idle(3, 0));
        cyc(1, 1, 0, 0, 0, "start", e_load(3, 0));
        nop("play0", e_play(3, 0));
        cyc(1, 1, 0, 0, 0, "play_sbign", e_play(3, 0));

        // Single hit: 4 freeze cycles, respawn, play
        cyc(1, 0, 1, 0, 0, "hit1", e_lost(2, 0));
        hold_respawn(2, 0);

        // Clear and hit together: clear wins, bonus life, next level
        cyc(1, 0, 1, 0, 1, "clr_hit", e_done(2, 0));
        for (int i = 0; i < 3; i++) nop("done_hold", e_done(2, 0));
        nop("load_l1", e_load(3, 1));
        nop("play_l1", e_play(3, 1));

        // timeUp acts as a hit
        cyc(1, 0, 0, 1, 0, "timeup", e_lost(2, 1));
        hold_respawn(2, 1);

        // Clear last level: win, no bonus
        cyc(1, 0, 0, 0, 1, "clr_last", e_done(2, 1));
        for (int i = 0; i < 3; i++) nop("done_hold2", e_done(2, 1));
        nop("win", e_win(2, 1));
        cyc(1, 0, 1, 1, 1, "win_sticky", e_win(2, 1));
        cyc(1, 1, 0, 0, 0, "restart_w", e_load(3, 0));
        nop("play_r", e_play(3, 0));

        // Three hits down to zero lives, then lose
        cyc(1, 0, 1, 0, 0, "hit_a", e_lost(2, 0));
        hold_respawn(2, 0);
        cyc(1, 0, 1, 0, 0, "hit_b", e_lost(1, 0));
        hold_respawn(1, 0);
        cyc(1, 0, 1, 0, 0, "hit_c", e_lost(0, 0));
        nop("lose", e_lose(0, 0));
        for (int i = 0; i < 100; i++)
            cyc(1, 0, i[0], i[1], i[2], "lose_stable", e_lose(0, 0));
        cyc(1, 1, 0, 0, 0, "restart_l", e_load(3, 0));
        nop("play_r2", e_play(3, 0));

        // Reset in the middle of a LIFE_LOST hold
        cyc(1, 0, 1, 0, 0, "hit_d", e_lost(2, 0));
        nop("lost_mid", e_lost(2, 0));
        cyc(0, 0, 0, 0, 0, "mid_reset", e_idle(3, 0));
        nop("post_reset", e_idle(3, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
